// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and enum types for the iterative AES-128 round sequencer.
package aes_pkg;

  localparam int AES_DW = 128;
  localparam int AES_NR = 10;
  localparam int AES_CW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_seq_state_t;

  typedef enum logic [1:0] {
    CNT_HOLD  = 2'd0,
    CNT_LOAD1 = 2'd1,
    CNT_INC   = 2'd2,
    CNT_CLEAR = 2'd3
  } aes_cnt_op_t;

endpackage

// File: rtl/aes_round_counter.sv
// aes_round_counter: round counter with load-1, saturating increment and clear.
// is_last flags the final round, which skips MixColumns.
module aes_round_counter
  import aes_pkg::*;
#(
  parameter int NR = AES_NR,
  parameter int CW = AES_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  aes_cnt_op_t   op,
  output logic [CW-1:0] count,
  output logic          is_last
);

  // Round counter register; increment saturates so the count never passes NR
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case (op)
        CNT_LOAD1: count <= CW'(1);
        CNT_INC:   if (count < CW'(NR)) count <= count + CW'(1);
        CNT_CLEAR: count <= '0;
        default:   count <= count;
      endcase
    end
  end

  assign is_last = (count == CW'(NR));

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryption controller. Owns the state
// register, round counter and round-key index; the shared round datapath and the
// round-key store live outside. One block in flight at a time: accept, NR rounds,
// then hold the ciphertext until the consumer takes it.
// Optional feature macro: AES_SEQ_ABORT_EN (adds the 'abort' input).
module aes_round_sequencer
  import aes_pkg::*;
#(
  parameter int DW = AES_DW,
  parameter int NR = AES_NR,
  parameter int CW = AES_CW
) (
  input  logic          clk,
  input  logic          rst,
`ifdef AES_SEQ_ABORT_EN
  input  logic          abort,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CW-1:0] rk_idx,
  input  logic [DW-1:0] rk_i,
  output logic [DW-1:0] rnd_state_o,
  output logic          rnd_last_o,
  input  logic [DW-1:0] rnd_state_i
);

  aes_seq_state_t state, state_next;
  logic [DW-1:0]  state_reg, state_reg_next;
  aes_cnt_op_t    cnt_op;
  logic [CW-1:0]  count;
  logic           is_last;
  logic           abort_req;

`ifdef AES_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  aes_round_counter #(
    .NR(NR),
    .CW(CW)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .op     (cnt_op),
    .count  (count),
    .is_last(is_last)
  );

  // FSM state and cipher state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      state_reg <= '0;
    end else begin
      state     <= state_next;
      state_reg <= state_reg_next;
    end
  end

  // Next-state, counter control and handshake outputs
  always_comb begin
    state_next     = state;
    state_reg_next = state_reg;
    cnt_op         = CNT_HOLD;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    rk_idx         = '0;
    rnd_last_o     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_reg_next = in_data ^ rk_i;
          cnt_op         = CNT_LOAD1;
          state_next     = ROUND;
        end
      end
      ROUND: begin
        rk_idx     = count;
        rnd_last_o = is_last;
        if (abort_req) begin
          cnt_op     = CNT_CLEAR;
          state_next = IDLE;
        end else begin
          state_reg_next = rnd_state_i;
          if (is_last) begin
            state_next = DONE;
          end else begin
            cnt_op = CNT_INC;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (abort_req || out_ready) begin
          cnt_op     = CNT_CLEAR;
          state_next = IDLE;
        end
      end
      default: begin
        cnt_op     = CNT_CLEAR;
        state_next = IDLE;
      end
    endcase
  end

  assign out_data    = state_reg;
  assign rnd_state_o = state_reg;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: self-checking bench for aes_round_sequencer. Supplies a
// behavioural AES round datapath and key schedule, checks known-answer vectors,
// round sequencing, backpressure, back-to-back blocks, reset and (when
// AES_SEQ_ABORT_EN is defined) abort.
module tb_aes_round_sequencer;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] key;
    logic [127:0] ct;
    int           hold;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   rk_idx;
  logic [127:0] rk_i;
  logic [127:0] rnd_state_o;
  logic         rnd_last_o;
  logic [127:0] rnd_state_i;
`ifdef AES_SEQ_ABORT_EN
  logic         abort;
`endif

  logic [7:0]   sbox_tab [256];
  logic [127:0] rk_table [11];
  vec_t         vecs [3];
  int           tests_run;
  int           tests_failed;

  aes_round_sequencer dut (
    .clk        (clk),
    .rst        (rst),
`ifdef AES_SEQ_ABORT_EN
    .abort      (abort),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .rk_idx     (rk_idx),
    .rk_i       (rk_i),
    .rnd_state_o(rnd_state_o),
    .rnd_last_o (rnd_last_o),
    .rnd_state_i(rnd_state_i)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox_tab[s[127-8*i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        t[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        t[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        t[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res ^ rk;
  endfunction

  // Behavioural key store and round datapath surrounding the sequencer
  assign rk_i        = (rk_idx <= 4'd10) ? rk_table[rk_idx] : '0;
  assign rnd_state_i = aes_round(rnd_state_o, rk_i, rnd_last_o);

  task automatic load_keys(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) rk_table[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_in_ready"},  128'(in_ready),   128'(1));
    checkOutput({tag, "_out_valid"}, 128'(out_valid),  128'(0));
    checkOutput({tag, "_rk_idx"},    128'(rk_idx),     128'(0));
    checkOutput({tag, "_rnd_last"},  128'(rnd_last_o), 128'(0));
    checkOutput({tag, "_out_data"},  out_data,         128'(0));
  endtask

  // Full block: accept, watch rounds, hold in DONE for v.hold cycles, then hand off
  task automatic applyStimulus(input vec_t v, input string tag);
    int cyc;
    load_keys(v.key);
    in_data  = v.pt;
    in_valid = 1'b1;
    checkOutput({tag, "_accept_ready"}, 128'(in_ready), 128'(1));
    checkOutput({tag, "_accept_rk_idx"}, 128'(rk_idx), 128'(0));
    step();
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      if (cyc <= 10) begin
        checkOutput({tag, "_rk_idx_seq"}, 128'(rk_idx), 128'(cyc));
        checkOutput({tag, "_rnd_last_seq"}, 128'(rnd_last_o), 128'(cyc == 10));
      end
      step();
      cyc++;
    end
    checkOutput({tag, "_latency"}, 128'(cyc), 128'(11));
    for (int h = 0; h < v.hold; h++) begin
      checkOutput({tag, "_hold_valid"}, 128'(out_valid), 128'(1));
      checkOutput({tag, "_hold_data"},  out_data,        v.ct);
      checkOutput({tag, "_hold_ready"}, 128'(in_ready),  128'(0));
      step();
    end
    checkOutput({tag, "_ciphertext"}, out_data,       v.ct);
    checkOutput({tag, "_done_valid"}, 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checkOutput({tag, "_post_valid"}, 128'(out_valid), 128'(0));
    checkOutput({tag, "_post_ready"}, 128'(in_ready),  128'(1));
  endtask

  initial begin
    logic [127:0] outs [$];
    int           acc_cycle [2];
    int           n_acc;
    int           seen;
    logic         acc;
    logic         ov;

    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_calc(8'(i));
    for (int r = 0; r < 11; r++) rk_table[r] = '0;

    vecs[0] = '{pt: 128'h3243f6a8885a308d313198a2e0370734, key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                ct: 128'h3925841d02dc09fbdc118597196a0b32, hold: 5};
    vecs[1] = '{pt: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, hold: 0};
    vecs[2] = '{pt: 128'h0, key: 128'h0,
                ct: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, hold: 2};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef AES_SEQ_ABORT_EN
    abort     = 1'b0;
`endif
    step();
    step();
    rst = 1'b0;
    step();
    check_reset_values("reset");

    for (int i = 0; i < 3; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: in_valid stays high, out_ready stays high; one DONE cycle between blocks
    load_keys(vecs[0].key);
    in_data   = vecs[0].pt;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    n_acc     = 0;
    for (int n = 0; n < 60; n++) begin
      acc = in_valid && in_ready;
      ov  = out_valid;
      if (ov) outs.push_back(out_data);
      step();
      if (acc) begin
        if (n_acc < 2) acc_cycle[n_acc] = n;
        n_acc++;
        if (n_acc == 1) in_data = vecs[1].pt;
        else in_valid = 1'b0;
      end
      if (ov && outs.size() == 1) load_keys(vecs[1].key);
      if (outs.size() == 2) break;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("b2b_accepts", 128'(n_acc), 128'(2));
    checkOutput("b2b_interval", 128'(acc_cycle[1] - acc_cycle[0]), 128'(12));
    checkOutput("b2b_outputs", 128'(outs.size()), 128'(2));
    if (outs.size() >= 1) checkOutput("b2b_ct0", outs[0], vecs[0].ct);
    if (outs.size() >= 2) checkOutput("b2b_ct1", outs[1], vecs[1].ct);
    step();

    // Reset during round 5 discards the block
    load_keys(vecs[0].key);
    in_data  = vecs[0].pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checkOutput("midrst_pre_rk_idx", 128'(rk_idx), 128'(5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_values("midrst");
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) seen++;
      step();
    end
    checkOutput("midrst_no_output", 128'(seen), 128'(0));
    applyStimulus(vecs[0], "after_rst");

`ifdef AES_SEQ_ABORT_EN
    // Abort in round 3 returns to IDLE without producing output
    load_keys(vecs[1].key);
    in_data  = vecs[1].pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    checkOutput("abort_pre_rk_idx", 128'(rk_idx), 128'(3));
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abort_in_ready", 128'(in_ready), 128'(1));
    checkOutput("abort_out_valid", 128'(out_valid), 128'(0));
    checkOutput("abort_rk_idx", 128'(rk_idx), 128'(0));
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (out_valid) seen++;
      step();
    end
    checkOutput("abort_no_output", 128'(seen), 128'(0));

    // Abort together with out_ready in DONE
    in_data  = vecs[1].pt;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 40) begin
      step();
      seen++;
    end
    checkOutput("abort_done_reached", 128'(out_valid), 128'(1));
    abort     = 1'b1;
    out_ready = 1'b1;
    step();
    abort     = 1'b0;
    out_ready = 1'b0;
    checkOutput("abort_done_valid", 128'(out_valid), 128'(0));
    checkOutput("abort_done_ready", 128'(in_ready), 128'(1));
    checkOutput("abort_done_rk_idx", 128'(rk_idx), 128'(0));
    applyStimulus(vecs[2], "after_abort");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
